// File: rtl/count_capture.sv
// Timestamp capture: synchronizes an asynchronous event strobe, and on each
// rising edge pushes the current count into a show-ahead FIFO with sticky overflow.
module count_capture #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         count_in,
  input  logic                     event_in,
  output logic [WIDTH-1:0]         cap_data,
  output logic                     cap_valid,
  input  logic                     cap_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic             s1_q, s2_q, s3_q;
  logic             edge_det;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             full, pop, wr_en;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= event_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_det = s2_q & ~s3_q;
  assign full     = (level_q == LW'(DEPTH));
  assign pop      = valid_q & cap_ready;
  // A full FIFO still accepts the push when the head is leaving on the same edge.
  assign wr_en    = edge_det & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (clr_ovf)              ovf_d = 1'b0;
    if (edge_det && !wr_en)   ovf_d = 1'b1;
    // Valid trails the first write into an empty FIFO by one cycle but drops with the last pop.
    valid_d = (level_q != '0) && (level_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= count_in;
  end

  assign cap_data  = mem_q[rd_ptr_q];
  assign cap_valid = valid_q;
  assign level     = level_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_count_capture.sv
// Bench for count_capture: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed timestamps.
module tb_count_capture;
  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [WIDTH-1:0]  count_in;
  logic              event_in;
  logic [WIDTH-1:0]  cap_data;
  logic              cap_valid;
  logic              cap_ready;
  logic [2:0]        level;
  logic              overflow;
  logic              clr_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  count_capture #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .event_in(event_in),
    .cap_data(cap_data), .cap_valid(cap_valid), .cap_ready(cap_ready),
    .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  // Reference model: stored timestamps, sticky flag, event sample history.
  logic [WIDTH-1:0] mq[$];
  bit               m_ovf;
  int               m_prev;
  bit               m_samp[$];

  function automatic bit m_valid();
    return (mq.size() > 0) && (m_prev > 0);
  endfunction

  always @(posedge clk or negedge reset) begin
    int lvl;
    bit vld, pop, cap, s2ago, s3ago;
    if (!reset) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_prev = 0;
      m_samp.delete();
    end else begin
      lvl   = mq.size();
      vld   = m_valid();
      pop   = vld && cap_ready;
      s2ago = (m_samp.size() >= 2) ? m_samp[m_samp.size()-2] : 1'b0;
      s3ago = (m_samp.size() >= 3) ? m_samp[m_samp.size()-3] : 1'b0;
      cap   = s2ago && !s3ago;
      if (pop) void'(mq.pop_front());
      if (clr_ovf) m_ovf = 1'b0;
      if (cap) begin
        if (lvl == DEPTH && !pop) m_ovf = 1'b1;
        else mq.push_back(count_in);
      end
      m_prev = lvl;
      m_samp.push_back(event_in);
      if (m_samp.size() > 3) void'(m_samp.pop_front());
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_model();
    bit v;
    v = m_valid();
    check("model_level", 32'(level), 32'(mq.size()));
    check("model_valid", 32'(cap_valid), 32'(v));
    check("model_ovf", 32'(overflow), 32'(m_ovf));
    if (v) check("model_data", 32'(cap_data), 32'(mq[0]));
  endtask

  // One clock: compare on the falling edge, then drive new inputs 2ns after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmp_model();
      @(posedge clk);
      #2;
      count_in = count_in + 16'd1;
    end
  endtask

  task automatic pulse();
    event_in = 1'b1;
    tick(1);
    event_in = 1'b0;
    tick(3);
  endtask

  initial begin
    reset = 1'b0; event_in = 1'b0; cap_ready = 1'b0; clr_ovf = 1'b0; count_in = '0;
    tick(3);
    reset = 1'b1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(cap_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    tick(2);

    // Single capture: 0x0100 at edge k, entry is the count at edge k+2.
    count_in = 16'h0100; event_in = 1'b1;
    tick(1);
    event_in = 1'b0;
    tick(2);
    check("single_level", 32'(level), 32'd1);
    check("single_valid_lag", 32'(cap_valid), 32'd0);
    tick(1);
    check("single_valid", 32'(cap_valid), 32'd1);
    check("single_data", 32'(cap_data), 32'h0102);
    cap_ready = 1'b1;
    tick(2);
    check("single_drain", 32'(level), 32'd0);
    tick(2);
    check("ready_empty", 32'(level), 32'd0);
    cap_ready = 1'b0;

    // Fill and overflow: five separated events, fifth dropped.
    count_in = 16'h1000;
    for (int i = 0; i < 5; i++) pulse();
    check("fill_level", 32'(level), 32'd4);
    check("fill_ovf", 32'(overflow), 32'd1);
    check("fill_head", 32'(cap_data), 32'h1002);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop.
    count_in = 16'h2000; event_in = 1'b1;
    tick(1);
    event_in = 1'b0;
    tick(1);
    cap_ready = 1'b1;
    tick(1);
    cap_ready = 1'b0;
    check("fullpp_level", 32'(level), 32'd4);
    check("fullpp_ovf", 32'(overflow), 32'd0);
    check("fullpp_head", 32'(cap_data), 32'h1006);
    cap_ready = 1'b1;
    tick(6);
    check("fullpp_drain", 32'(level), 32'd0);
    cap_ready = 1'b0;

    // Count wrap-around captured verbatim.
    count_in = 16'hFFFD; event_in = 1'b1;
    tick(1);
    event_in = 1'b0;
    tick(2);
    event_in = 1'b1; count_in = 16'hFFFE;
    tick(1);
    event_in = 1'b0;
    tick(2);
    check("wrap_level", 32'(level), 32'd2);
    check("wrap_first", 32'(cap_data), 32'hFFFF);
    cap_ready = 1'b1;
    tick(1);
    check("wrap_second", 32'(cap_data), 32'h0000);
    check("wrap_valid", 32'(cap_valid), 32'd1);
    tick(2);
    cap_ready = 1'b0;

    // Held event: one capture only.
    count_in = 16'h5000; event_in = 1'b1;
    tick(20);
    event_in = 1'b0;
    tick(3);
    check("held_level", 32'(level), 32'd1);
    check("held_data", 32'(cap_data), 32'h5002);
    cap_ready = 1'b1;
    tick(2);
    cap_ready = 1'b0;

    // Reset mid-operation with level 3 and overflow set.
    count_in = 16'h4000;
    for (int i = 0; i < 5; i++) pulse();
    cap_ready = 1'b1;
    tick(1);
    cap_ready = 1'b0;
    check("pre_rst_level", 32'(level), 32'd3);
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_valid", 32'(cap_valid), 32'd0);
    check("async_rst_ovf", 32'(overflow), 32'd0);
    event_in = 1'b1;
    tick(2);
    reset = 1'b1; count_in = 16'h3000;
    tick(2);
    check("post_rst_nocap", 32'(level), 32'd0);
    tick(1);
    check("post_rst_level", 32'(level), 32'd1);
    tick(1);
    check("post_rst_valid", 32'(cap_valid), 32'd1);
    check("post_rst_data", 32'(cap_data), 32'h3002);
    tick(4);
    event_in = 1'b0;
    check("post_rst_once", 32'(level), 32'd1);
    cap_ready = 1'b1;
    tick(3);
    cap_ready = 1'b0;
    check("final_level", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
